// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the counter-compare PWM block.
package pwm_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CNT_MAX  = (1 << WIDTH) - 1;

  // Saturate a requested duty to the full-period value 2^width.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                             input int unsigned width);
    logic [31:0] full;
    full = 32'(1) << width;
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled clock cycles.
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = pwm_pkg::PRESCALE
) (
  input  logic ck,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  assign tick = en && (presc == PRESC_LAST);

  always_ff @(posedge ck) begin
    if (rst) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_core.sv
// Counter-compare PWM with a one-deep pending duty buffer that is
// transferred to the active duty only at period boundaries.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = pwm_pkg::WIDTH,
  parameter int unsigned PRESCALE = pwm_pkg::PRESCALE
) (
  input  logic           ck,
  input  logic           rst,
  input  logic           en,
  input  logic [WIDTH:0] duty_in,
  input  logic           duty_valid,
  output logic           duty_ready,
  output logic           pwm_raw,
  output logic           period_end
);

  localparam int unsigned DW = WIDTH + 1;
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic          tick;
  logic          bnd;
  logic          accept;
  logic [WIDTH-1:0] cnt;
  logic [DW-1:0] duty_act;
  logic [DW-1:0] duty_pend;
  logic [DW-1:0] duty_clamped;
  logic          pend_full;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .ck  (ck),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign duty_clamped = DW'(clamp_duty(32'(duty_in), WIDTH));
  assign duty_ready   = !rst && !pend_full;
  assign accept       = duty_valid && duty_ready;
  assign bnd          = tick && (cnt == CNT_LAST);
  // Compare is one bit wider than cnt so 2^WIDTH means always high.
  assign pwm_raw      = en && ({1'b0, cnt} < duty_act);

  always_ff @(posedge ck) begin
    if (rst) begin
      cnt        <= '0;
      duty_act   <= '0;
      duty_pend  <= '0;
      pend_full  <= 1'b0;
      period_end <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= cnt + WIDTH'(1);
      end
      // Accept needs an empty buffer, so it never races a transfer.
      if (bnd && pend_full) begin
        duty_act <= duty_pend;
      end
      if (accept) begin
        duty_pend <= duty_clamped;
        pend_full <= 1'b1;
      end else if (bnd) begin
        pend_full <= 1'b0;
      end
      period_end <= bnd;
    end
  end

endmodule

// File: doc/pwm_core.md
# pwm_core

Counter-compare PWM generator with a prescaler and a double-buffered duty register. Produces the raw PWM level that the downstream single-bit output flop (clocked on `ck`) retimes before it leaves the chip. Duty updates arrive over a valid/ready handshake and take effect only at period boundaries, so every emitted period is glitch-free and complete.

## Interface
- `WIDTH`, 8: counter width. The period is 2^WIDTH ticks.
- `PRESCALE`, 4: number of `ck` cycles per counter tick. Must be ≥1.
- `ck`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  run enable
- `duty_in`  in  WIDTH+1  requested duty in ticks (0 … 2^WIDTH)
- `duty_valid`  in  1  `duty_in` is valid
- `duty_ready`  out  1  pending buffer empty; an update can be accepted
- `pwm_raw`  out  1  PWM level; feeds the downstream retiming flop
- `period_end`  out  1  one-cycle pulse after each period boundary

## Operation
- State registers:
  - `presc` (prescaler count, 0…PRESCALE-1)
  - `cnt` (WIDTH bits)
  - `duty_act` (WIDTH+1)
  - `duty_pend` (WIDTH+1)
  - `pend_full`
  - `period_end`
- Reset values: all state is 0. During reset `duty_ready`=0, `pwm_raw`=0 and `period_end`=0. `duty_ready`=1 in the first cycle after `rst` deasserts.
- Tick: `tick` = `en` & (`presc` == PRESCALE-1).
  - When `en`=1: `presc` increments and wraps to 0 on `tick`.
  - When `en`=0: `presc` and `cnt` hold.
- Counter: on `tick`, `cnt` increments modulo 2^WIDTH.
- Boundary: `bnd` = `tick` & (`cnt` == 2^WIDTH-1). On `bnd`:
  - if `pend_full`, then `duty_act` <= `duty_pend` and `pend_full` <= 0;
  - `period_end` <= 1.
  - Otherwise `period_end` <= 0.
- Output: `pwm_raw` = `en` & (`cnt` < `duty_act`). The comparison is unsigned and WIDTH+1 bits wide.
  - `duty_act`=0 gives a constant low output.
  - `duty_act`=2^WIDTH gives a constant high output.
- Clamp: `duty_in` values greater than 2^WIDTH are stored as 2^WIDTH.
- Handshake: `duty_ready` = !`pend_full`. On `duty_valid` & `duty_ready`, `duty_pend` <= clamp(`duty_in`) and `pend_full` <= 1.
  - `duty_valid` while `duty_ready`=0 is ignored. The producer must hold `duty_valid` until it sees `duty_ready`.
- Simultaneous accept and `bnd` in one cycle:
  - the transfer at `bnd` uses only a value that was pending at the start of the cycle;
  - the new value is captured into `duty_pend` and applies at the next boundary;
  - `pend_full` ends the cycle at 1.
- While `en`=0: the handshake still operates and `pend_full` can be set, but no boundary occurs, so no transfer happens.
- `rst` mid-period returns all state to reset values on that edge and discards any pending update.

## Timing
- Period length is 2^WIDTH × PRESCALE `ck` cycles. Defaults: 1024 cycles.
- `pwm_raw` depends combinationally on `cnt`, `duty_act` and `en` only. It carries no `duty_in` path. The downstream flop adds one cycle of latency.
- Duty latency: a new duty value is visible on `pwm_raw` starting at `cnt`=0 of the first period that begins after acceptance. That is at most one full period plus one cycle.
- `period_end` is high for exactly one `ck` cycle, the cycle in which `cnt`=0 and `presc`=0 following the wrap.
- `duty_ready` falls on the edge after acceptance. It rises on the edge after `bnd`.

## Structure
- Shared package `pwm_pkg`:
  - default `WIDTH` and `PRESCALE`;
  - the function `clamp_duty`;
  - the constant `CNT_MAX` = 2^WIDTH-1.
- Sub-module `pwm_tick_gen`: the prescaler. Inputs are `ck`, `rst` and `en`; output is `tick`.
- The counter, duty buffering and compare stay in `pwm_core`.

## Test plan
All scenarios use WIDTH=8, PRESCALE=1 unless stated.
- **Reset:**
  - stimulus: hold `rst` high for 3 cycles with `en`=1 and `duty_valid`=1;
  - response: `pwm_raw`=0, `duty_ready`=0 and `period_end`=0 throughout; `duty_ready`=1 in the cycle after release.
- **Basic duty:**
  - stimulus: write 64, then run 3 periods;
  - response: from the second boundary on, each 256-cycle period has exactly 64 high cycles starting at `cnt`=0; `period_end` pulses every 256 cycles.
- **Extremes:**
  - stimulus: write 0, then 256, then 300;
  - response: constant low; then constant high; then clamped to 256, constant high.
- **Update mid-period:**
  - stimulus: duty 128 active, write 32 at `cnt`=50;
  - response: the current period still has 128 high cycles; the next period has 32; `duty_ready` is low from acceptance until after `bnd`.
- **Simultaneous accept and boundary:**
  - stimulus: pending 100, then present 20 in the `bnd` cycle;
  - response: the next period uses 100, the following period uses 20.
- **Prescale and enable:**
  - stimulus: PRESCALE=4, deassert `en` for 10 cycles mid-period;
  - response: `pwm_raw`=0 and `cnt` frozen while disabled; the period is extended by exactly 10 cycles, to 1034; no extra `period_end`.
